reg_pipeline: RTL



---
 rtl/reg_pipeline_pkg.sv | 8 +
 rtl/reg_pipe_stage.sv | 39 +++
 rtl/reg_pipeline.sv | 89 ++++++++
 3 files changed

// File: rtl/reg_pipeline_pkg.sv
// Shared defaults for the register pipeline slice.
// Kept tiny on purpose: the pipeline itself needs no shared types.
package reg_pipeline_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/reg_pipe_stage.sv
// One stage of the pipeline: a valid bit plus a data register.
// Data loads only when the stage receives a word; it holds otherwise, even when invalid.
module reg_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] dat_in,
  input  logic             vld_in,
  input  logic             advance,
  output logic             vld_q,
  output logic [WIDTH-1:0] dat_q
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;

  // Load wins over advance: the stage refills in the same cycle it empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_dat <= RESET_VAL;
    end else if (flush) begin
      r_vld <= 1'b0;
    end else if (load) begin
      r_vld <= vld_in;
      r_dat <= dat_in;
    end else if (advance) begin
      r_vld <= 1'b0;
    end
  end

  assign vld_q = r_vld;
  assign dat_q = r_dat;

endmodule

// File: rtl/reg_pipeline.sv
// Stallable, bubble-collapsing register pipeline with valid/ready flow control.
// Handshake: a word moves on a port in any cycle where valid && ready are both high at the rising edge.
module reg_pipeline
  import reg_pipeline_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] w_vld;
  logic [DEPTH-1:0] w_adv;
  logic [WIDTH-1:0] w_dat [DEPTH];
  logic             w_accept;
  logic             w_xfer;
  logic [CNT_W-1:0] r_occ;

  // Advance chain is resolved from the output end backwards, so a free or
  // emptying downstream stage lets every valid stage behind it move.
  always_comb begin
    logic [DEPTH-1:0] v_adv;
    v_adv            = '0;
    v_adv[DEPTH-1]   = w_vld[DEPTH-1] && out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      v_adv[k] = w_vld[k] && (!w_vld[k+1] || v_adv[k+1]);
    end
    w_adv = v_adv;
  end

  assign in_ready = !rst && !flush && (!w_vld[0] || w_adv[0]);
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = w_adv[DEPTH-1];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             w_ld;
    logic [WIDTH-1:0] w_din;

    if (k == 0) begin : g_head
      assign w_ld  = w_accept;
      assign w_din = in_data;
    end else begin : g_body
      assign w_ld  = w_adv[k-1];
      assign w_din = w_dat[k-1];
    end

    reg_pipe_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .load   (w_ld),
      .dat_in (w_din),
      .vld_in (1'b1),
      .advance(w_adv[k]),
      .vld_q  (w_vld[k]),
      .dat_q  (w_dat[k])
    );
  end

  // Accept is already blocked during flush, so only the transfer can race the clear.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ <= '0;
    end else if (w_accept && !w_xfer) begin
      r_occ <= r_occ + CNT_W'(1);
    end else if (!w_accept && w_xfer) begin
      r_occ <= r_occ - CNT_W'(1);
    end
  end

  assign out_valid = w_vld[DEPTH-1];
  assign out_data  = w_dat[DEPTH-1];
  assign occupancy = r_occ;

endmodule
